mean_filter_3x3_8bit: RTL and testbench

Downstream consumer of the two-row line buffer in the mean-filter path: it takes the live 8-bit pixel stream together with the line buffer's one-row-up (`taps0x`) and two-rows-up (`taps1x`) outputs. It builds a 3x3 window with column shift registers and computes the exact floor mean of the 9 pixels through a 5-stage pipeline. It re-emits frame sync (vsync/href/clken) aligned to the filtered data for the next processor stage.

---
 rtl/mean_filter_3x3_8bit.sv | 119 +++++++++++
 tb/tb_mean_filter_3x3_8bit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mean_filter_3x3_8bit.sv
// mean_filter_3x3_8bit: 3x3 floor-mean filter on an 8-bit pixel stream with two line-buffer taps.
// Ports:
//   clock, rst_n (async active-low)
//   pre_frame_vsync/href/clken, pre_img_y : input frame sync and current pixel
//   taps0x / taps1x                       : line buffer taps (one / two rows up), 1 clock behind pre_img_y
//   post_frame_vsync/href/clken           : sync delayed 6 clocks to match post_img_y
//   post_img_y                            : filtered pixel
// Build option: MEAN_BORDER_ZERO_EN -> border windows output 0; otherwise the raw center pixel.
module mean_filter_3x3_8bit #(
  parameter int COL_W    = 12,
  parameter int ROW_W    = 11,
  parameter int DIV_MULT = 7282
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_href,
  input  logic       pre_frame_clken,
  input  logic [7:0] pre_img_y,
  input  logic [7:0] taps0x,
  input  logic [7:0] taps1x,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_y
);
  // Index 0 is the tap-aligned stage 0, index 5 drives the outputs.
  logic [5:0]       r_vs, r_hr, r_ce;
  logic [7:0]       r_y0;
  logic [7:0]       r_p11, r_p12, r_p13, r_p21, r_p22, r_p23, r_p31, r_p32, r_p33;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_bd1;
  logic [4:2]       r_bd;
  logic [7:0]       r_ctr2, r_ctr3, r_ctr4;
  logic [9:0]       r_s1, r_s2, r_s3;
  logic [11:0]      r_sum;
  logic [24:0]      r_prod;
  logic [7:0]       r_out;
  logic             w_border;
  logic [7:0]       w_res;
  logic             w_unused;
  // Counters hold the position of the beat currently in stage 0, before it is counted.
  assign w_border = (r_row < ROW_W'(2)) || (r_col < COL_W'(2));
`ifdef MEAN_BORDER_ZERO_EN
  assign w_res = r_bd[4] ? 8'd0 : r_prod[23:16];
`else
  assign w_res = r_bd[4] ? r_ctr4 : r_prod[23:16];
`endif
  assign w_unused = ^{r_prod[24], r_prod[15:0], r_ctr4};
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_vs   <= '0;
      r_hr   <= '0;
      r_ce   <= '0;
      r_y0   <= '0;
      r_p11  <= '0;
      r_p12  <= '0;
      r_p13  <= '0;
      r_p21  <= '0;
      r_p22  <= '0;
      r_p23  <= '0;
      r_p31  <= '0;
      r_p32  <= '0;
      r_p33  <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_bd1  <= 1'b0;
      r_bd   <= '0;
      r_ctr2 <= '0;
      r_ctr3 <= '0;
      r_ctr4 <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_sum  <= '0;
      r_prod <= '0;
      r_out  <= '0;
    end else begin
      r_vs <= {r_vs[4:0], pre_frame_vsync};
      r_hr <= {r_hr[4:0], pre_frame_href};
      r_ce <= {r_ce[4:0], pre_frame_clken};
      r_y0 <= pre_img_y;
      // Window advances only on aligned beats; newest column enters at p_3.
      if (r_ce[0]) begin
        r_p11 <= r_p12;
        r_p12 <= r_p13;
        r_p13 <= taps1x;
        r_p21 <= r_p22;
        r_p22 <= r_p23;
        r_p23 <= taps0x;
        r_p31 <= r_p32;
        r_p32 <= r_p33;
        r_p33 <= r_y0;
        r_bd1 <= w_border;
      end
      r_col <= !r_hr[0] ? '0 : (r_ce[0] && !(&r_col)) ? r_col + 1'b1 : r_col;
      r_row <= (r_vs[0] && !r_vs[1]) ? '0 :
               (r_hr[1] && !r_hr[0] && !(&r_row)) ? r_row + 1'b1 : r_row;
      r_s1   <= 10'(r_p11) + 10'(r_p12) + 10'(r_p13);
      r_s2   <= 10'(r_p21) + 10'(r_p22) + 10'(r_p23);
      r_s3   <= 10'(r_p31) + 10'(r_p32) + 10'(r_p33);
      r_ctr2 <= r_p22;
      r_bd[2] <= r_bd1;
      r_sum  <= 12'(r_s1) + 12'(r_s2) + 12'(r_s3);
      r_ctr3 <= r_ctr2;
      r_bd[3] <= r_bd[2];
      // sum*7282 >> 16 equals floor(sum/9) for every sum up to 2295.
      r_prod <= 25'(r_sum) * 25'(DIV_MULT);
      r_ctr4 <= r_ctr3;
      r_bd[4] <= r_bd[3];
      r_out  <= w_res;
    end
  end
  assign post_frame_vsync = r_vs[5];
  assign post_frame_href  = r_hr[5];
  assign post_frame_clken = r_ce[5];
  assign post_img_y       = r_out;
endmodule

// File: tb/tb_mean_filter_3x3_8bit.sv
// tb_mean_filter_3x3_8bit: directed, table-driven bench for mean_filter_3x3_8bit.
module tb_mean_filter_3x3_8bit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic [7:0] y = '0, t0 = '0, t1 = '0;
  logic       o_vs, o_hr, o_ce;
  logic [7:0] o_y;

  always #5 clk = ~clk;

  mean_filter_3x3_8bit dut (
    .clock(clk), .rst_n(rst_n),
    .pre_frame_vsync(vs), .pre_frame_href(hr), .pre_frame_clken(ce), .pre_img_y(y),
    .taps0x(t0), .taps1x(t1),
    .post_frame_vsync(o_vs), .post_frame_href(o_hr), .post_frame_clken(o_ce), .post_img_y(o_y)
  );

  typedef struct {
    logic [8:0][7:0] w;
    logic [7:0]      e;
  } vec_t;

  int chks = 0, fails = 0;
  int img[8][8];
  int expq[$], got[$];
  int prev_up = 0, nxt0 = 0, nxt1 = 0, cyc = 0, in_first = -1, out_first = -1;
  logic [5:0] hv = '0, hh = '0, hc = '0;

  task automatic chk(input string nm, input int act, input int ex);
    chks++;
    if (act != ex) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, ex);
    end
  endtask

  // One clock: drive inputs, keep the line-buffer tap model and the expected stream,
  // then check the delayed sync outputs and collect output beats.
  task automatic cycle(input bit v, input bit h, input bit c, input int r, input int cc);
    int up, up2, e, s;
    @(posedge clk);
    hv = {hv[4:0], vs};
    hh = {hh[4:0], hr};
    hc = {hc[4:0], ce};
    cyc++;
    #1;
    t0 = 8'(nxt0);
    t1 = 8'(nxt1);
    vs = v;
    hr = h;
    ce = c;
    y  = c ? 8'(img[r][cc]) : 8'd0;
    if (c) begin
      up  = (r >= 1) ? img[r-1][cc] : 0;
      up2 = (r >= 2) ? img[r-2][cc] : 0;
      if (r < 2 || cc < 2) begin
`ifdef MEAN_BORDER_ZERO_EN
        e = 0;
`else
        e = prev_up;
`endif
      end else begin
        s = 0;
        for (int i = r - 2; i <= r; i++)
          for (int j = cc - 2; j <= cc; j++) s += img[i][j];
        e = s / 9;
      end
      expq.push_back(e);
      prev_up = up;
      nxt0 = up;
      nxt1 = up2;
      if (in_first < 0) in_first = cyc;
    end
    @(negedge clk);
    chk("dly_vsync", int'(o_vs), int'(hv[5]));
    chk("dly_href", int'(o_hr), int'(hh[5]));
    chk("dly_clken", int'(o_ce), int'(hc[5]));
    if (o_ce) begin
      got.push_back(int'(o_y));
      if (out_first < 0) out_first = cyc;
    end
  endtask

  task automatic send_frame(input int rows, input int cols, input bit gap, input int stop_at);
    int n = 0;
    repeat (2) cycle(1, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (n == stop_at) return;
        cycle(0, 1, 1, r, c);
        n++;
        if (gap) cycle(0, 1, 0, 0, 0);
      end
      repeat (3) cycle(0, 0, 0, 0, 0);
    end
    repeat (8) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic check_frame(input string nm);
    int n;
    chk({nm, "_count"}, got.size(), expq.size());
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_px%0d", nm, i), got[i], expq[i]);
    got.delete();
    expq.delete();
    in_first = -1;
    out_first = -1;
  endtask

  task automatic fill(input int v, input bit ramp);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = ramp ? c : v;
  endtask

  initial begin
    vec_t tab[9];
    tab[0] = '{w: {9{8'd90}}, e: 8'd90};
    tab[1] = '{w: {9{8'd255}}, e: 8'd255};
    tab[2] = '{w: {8'd8, {8{8'd0}}}, e: 8'd0};
    tab[3] = '{w: {9{8'd1}}, e: 8'd1};
    tab[4] = '{w: {8'd8, 8'd9, {7{8'd0}}}, e: 8'd1};
    tab[5] = '{w: {8'd254, {8{8'd255}}}, e: 8'd254};
    tab[6] = '{w: {9{8'd9}}, e: 8'd9};
    tab[7] = '{w: {8'd8, {8{8'd9}}}, e: 8'd8};
    tab[8] = '{w: {9{8'd0}}, e: 8'd0};
    fill(0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_vsync", int'(o_vs), 0);
    chk("rst_href", int'(o_hr), 0);
    chk("rst_clken", int'(o_ce), 0);
    chk("rst_y", int'(o_y), 0);
    rst_n = 1'b1;

    fill(90, 0);
    send_frame(8, 8, 0, -1);
    chk("latency90", out_first - in_first, 6);
    chk("beats90", got.size(), 64);
    chk("int90", got.size() > 27 ? got[27] : -1, 90);
    check_frame("u90");

    fill(255, 0);
    send_frame(8, 8, 0, -1);
    chk("int255", got.size() > 63 ? got[63] : -1, 255);
    check_frame("u255");

    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 9; i++) img[i/3][i%3] = int'(tab[k].w[i]);
      send_frame(3, 3, 0, -1);
      chk($sformatf("tab%0d", k), got.size() == 9 ? got[8] : -1, int'(tab[k].e));
      check_frame($sformatf("tabf%0d", k));
    end

    fill(0, 1);
    send_frame(8, 8, 0, -1);
    chk("ramp_c2", got.size() > 18 ? got[18] : -1, 1);
    chk("ramp_c5", got.size() > 37 ? got[37] : -1, 4);
`ifdef MEAN_BORDER_ZERO_EN
    chk("border_r1c3", got.size() > 11 ? got[11] : -1, 0);
    chk("border_r4c0", got.size() > 32 ? got[32] : -1, 0);
`else
    chk("border_r1c3", got.size() > 11 ? got[11] : -1, 2);
    chk("border_r4c0", got.size() > 32 ? got[32] : -1, 7);
`endif
    check_frame("ramp");

    send_frame(8, 8, 1, -1);
    chk("gap_c5", got.size() > 37 ? got[37] : -1, 4);
    check_frame("ramp_gap");

    send_frame(8, 8, 0, 20);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vsync", int'(o_vs), 0);
    chk("mid_rst_href", int'(o_hr), 0);
    chk("mid_rst_clken", int'(o_ce), 0);
    chk("mid_rst_y", int'(o_y), 0);
    vs = 0; hr = 0; ce = 0; y = '0; t0 = '0; t1 = '0;
    hv = '0; hh = '0; hc = '0;
    got.delete();
    expq.delete();
    prev_up = 0; nxt0 = 0; nxt1 = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) cycle(0, 0, 0, 0, 0);
    chk("post_rst_beats", got.size(), 0);
    send_frame(8, 8, 0, -1);
    chk("post_rst_c5", got.size() > 37 ? got[37] : -1, 4);
    check_frame("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", chks, fails);
    $finish;
  end
endmodule
